dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter and sequencer for the processor's single-port data memory. It sits between the data memory and two masters: the core controller (port C, driven by the MOV load/store states) and a host/debug loader (port H, used to preload and inspect data memory). It serialises accesses with a request/done handshake, fixed-latency memory strobing, and round-robin resolution on contention.

## Interface
- AW, 8, data memory address width
- DW, 16, data word width
- clk  in  1  system clock, rising edge
- rst  in  1  reset; **one clock; reset is asynchronous and active-high**
- c_req  in  1  core request; held until c_done
- c_we  in  1  core access type: 1 = write, 0 = read
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_rdata  out  DW  core read data, valid when c_done
- c_done  out  1  one-cycle completion pulse to core
- h_req, h_we, h_addr, h_wdata, h_rdata, h_done: same as the c_ signals, for the host port
- D_rd  out  1  memory read strobe
- D_wr  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after D_rd
- busy  out  1  high in every state except IDLE
- owner  out  1  0 = core, 1 = host; port of the current or last transaction

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- **IDLE:**
  - If any req is high: pick a winner and latch its we/addr/wdata into internal registers; go to ACCESS.
  - Only one port requesting: that port wins.
  - Both requesting: winner = !last_owner (round-robin); last_owner updates on every grant.
- **ACCESS:**
  - D_rd = !we_q, D_wr = we_q; mem_addr = addr_q; mem_wdata = wdata_q.
  - Read goes to WAIT. Write goes to DONE.
- **WAIT:** capture mem_rdata into the winner's rdata register; go to DONE.
- **DONE:** pulse done for the winner; go to IDLE.
- The loser's req is ignored until the next IDLE. The loser must keep its req high.
- A requester must drop req in the cycle after done. If req is still high in IDLE, it is a new request.
- Inputs on a port are ignored while it is not being sampled in IDLE. Latched values are used, so requester changes mid-transaction do not affect the access.
- Each rdata holds its last read value until that port's next read completes. A write does not change rdata.
- D_rd and D_wr are never high simultaneously, and each is high for exactly one cycle per transaction.

## Timing
- **Reset values:**
  - State IDLE, last_owner = 1 (core wins the first contention), owner = 0.
  - All strobes, done and busy = 0.
  - Registered addr/wdata/rdata = 0.
- **Read:** req sampled in IDLE at cycle t; D_rd in t+1; rdata captured at the end of t+2; done in t+3.
- **Write:** req sampled at t; D_wr in t+1; done in t+2.
- **Throughput:**
  - Back-to-back reads from alternating ports: one completion every 4 cycles, because IDLE is a mandatory arbitration cycle.
  - Back-to-back writes: one completion every 3 cycles.
- Strobes, mem_addr, mem_wdata, done and busy are decoded from registered state and latched fields. There is no combinational path from any req to any output.
- **Reset mid-transaction:**
  - Immediate return to IDLE; strobes drop asynchronously.
  - No done is issued; the interrupted requester must re-request.
  - A write whose D_wr was cut by reset has undefined memory effect.

## Structure
- Package dmem_arb_pkg holds:
  - the state encoding (IDLE=2'b00, ACCESS=2'b01, WAIT=2'b10, DONE=2'b11);
  - the owner constants OWN_CORE=1'b0, OWN_HOST=1'b1;
  - the AW/DW defaults.
- One sub-module, rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: grant_valid, grant_idx.
- The FSM, field latches and rdata registers live in dmem_arbiter.
- Target size: 150–250 lines.

## Test plan
- **Reset:** assert rst mid-ACCESS of a core write to 0x10 → D_wr drops that cycle, busy=0, no c_done. After release, the first contention grants the core.
- **Single read:** core read 0x05, memory returns 0xBEEF → D_rd in t+1 only, c_done in t+3, c_rdata=0xBEEF, h_done stays 0.
- **Single write:** host write 0xA5A5 to 0x20 → D_wr=1, mem_addr=0x20, mem_wdata=0xA5A5 in t+1, h_done in t+2, h_rdata unchanged.
- **Contention:** c_req and h_req rise in the same cycle, both held → core served first, then host, then core. owner alternates 0,1,0; no done pulse overlaps another.
- **Field stability:** change c_addr from 0x05 to 0x07 during ACCESS → memory still sees 0x05.
- **Stuck req:** host holds h_req high after h_done with the core idle → a second host transaction starts at the next IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared state encoding, owner codes and width defaults for the
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_HOST = 1'b1;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin picker; on contention the port that did
//               not win last time is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        // A lone requester wins outright; with both active, alternate.
        grant_idx   = (&req) ? ~last : req[1];
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Core/host arbiter and fixed-latency sequencer for the single
//               port data memory (request/done handshake).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_done,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic [DW-1:0] h_rdata,
    output logic          h_done,
    output logic          D_rd,
    output logic          D_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    state_t        r_state;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_c_rdata;
    logic [DW-1:0] r_h_rdata;
    logic          r_owner;
    logic          r_last;

    logic          w_grant_valid;
    logic          w_grant_idx;

    rr_pick2 u_pick (
        .req         ({h_req, c_req}),
        .last        (r_last),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_c_rdata <= '0;
            r_h_rdata <= '0;
            r_owner   <= OWN_CORE;
            r_last    <= OWN_HOST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_idx;
                        r_last  <= w_grant_idx;
                        if (w_grant_idx == OWN_HOST) begin
                            r_we    <= h_we;
                            r_addr  <= h_addr;
                            r_wdata <= h_wdata;
                        end else begin
                            r_we    <= c_we;
                            r_addr  <= c_addr;
                            r_wdata <= c_wdata;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: r_state <= r_we ? DONE : WAIT;
                WAIT: begin
                    // Memory data is valid one cycle after the read strobe.
                    if (r_owner == OWN_HOST) begin
                        r_h_rdata <= mem_rdata;
                    end else begin
                        r_c_rdata <= mem_rdata;
                    end
                    r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs come only from registered state, so reset clears them at once.
    assign D_rd      = (r_state == ACCESS) && !r_we;
    assign D_wr      = (r_state == ACCESS) &&  r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign c_done    = (r_state == DONE) && (r_owner == OWN_CORE);
    assign h_done    = (r_state == DONE) && (r_owner == OWN_HOST);
    assign c_rdata   = r_c_rdata;
    assign h_rdata   = r_h_rdata;
    assign busy      = (r_state != IDLE);
    assign owner     = r_owner;

endmodule : dmem_arbiter
`default_nettype wire
